// File: rtl/car_x_controller_if.sv
// Bus between the keyboard/collision logic and the car X controller.
// With CAR_CRASH_COUNT_EN defined, the bus also carries the 4-bit crashCount output.
interface car_x_controller_if;
    logic              startOfFrame;
    logic              leftKey;
    logic              rightKey;
    logic              collision;
    logic              skidDir;
    logic signed [10:0] topLeftX;
    logic              carVisible;
    logic [1:0]        carState;
`ifdef CAR_CRASH_COUNT_EN
    logic [3:0]        crashCount;
`endif

    // Keyboard/collision side: drives the frame pulse, keys and collision events.
    modport master (
        output startOfFrame, leftKey, rightKey, collision, skidDir,
        input  topLeftX, carVisible, carState
`ifdef CAR_CRASH_COUNT_EN
        , input crashCount
`endif
    );

    // Controller side: consumes events, produces position, visibility and state.
    modport slave (
        input  startOfFrame, leftKey, rightKey, collision, skidDir,
        output topLeftX, carVisible, carState
`ifdef CAR_CRASH_COUNT_EN
        , output crashCount
`endif
    );
endinterface

// File: rtl/car_x_controller.sv
// Player car horizontal position sequencer: drive, skid, crash and respawn.
// The X position updates once per frame and clamps to the road edges.
// Optional: with CAR_CRASH_COUNT_EN defined, a saturating 4-bit crash counter is output on the bus.
module car_x_controller #(
    parameter logic signed [10:0] INIT_X         = 11'sd310,
    parameter logic signed [10:0] ROAD_LEFT      = 11'sd160,
    parameter logic signed [10:0] ROAD_RIGHT     = 11'sd448,
    parameter logic signed [11:0] STEP           = 12'sd2,
    parameter logic signed [11:0] SKID_STEP      = 12'sd4,
    parameter logic [7:0]         SKID_FRAMES    = 8'd16,
    parameter logic [7:0]         CRASH_FRAMES   = 8'd30,
    parameter logic [7:0]         RESPAWN_FRAMES = 8'd60
) (
    input  logic                     clk,
    input  logic                     reset,
    car_x_controller_if.slave        bus
);

    localparam logic [1:0] ST_DRIVE   = 2'd0;
    localparam logic [1:0] ST_SKID    = 2'd1;
    localparam logic [1:0] ST_CRASH   = 2'd2;
    localparam logic [1:0] ST_RESPAWN = 2'd3;

    localparam logic signed [11:0] LEFT_W  = {ROAD_LEFT[10], ROAD_LEFT};
    localparam logic signed [11:0] RIGHT_W = {ROAD_RIGHT[10], ROAD_RIGHT};

    logic signed [10:0] x_q, x_d;
    logic               vis_q, vis_d;
    logic [1:0]         state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic               dir_q, dir_d;

    logic [7:0]         cnt_dec;
    logic               pend_now;
    logic               dir_now;
    logic signed [11:0] x_wide;
    logic signed [11:0] key_delta;
    logic signed [11:0] key_x;
    logic signed [11:0] skid_x;

    function automatic logic off_road(input logic signed [11:0] v);
        return (v < LEFT_W) || (v > RIGHT_W);
    endfunction

    function automatic logic signed [10:0] clamp_road(input logic signed [11:0] v);
        if (v < LEFT_W)
            return ROAD_LEFT;
        else if (v > RIGHT_W)
            return ROAD_RIGHT;
        else
            return v[10:0];
    endfunction

    // Per-frame state machine plus collision latch between frame ticks
    always_comb begin
        x_d     = x_q;
        vis_d   = vis_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        dir_d   = dir_q;

        cnt_dec  = cnt_q - 8'd1;
        pend_now = pend_q | bus.collision;
        dir_now  = bus.collision ? bus.skidDir : dir_q;
        x_wide   = {x_q[10], x_q};

        key_delta = 12'sd0;
        if (bus.leftKey && !bus.rightKey)
            key_delta = -STEP;
        else if (bus.rightKey && !bus.leftKey)
            key_delta = STEP;
        key_x  = x_wide + key_delta;
        skid_x = dir_q ? (x_wide + SKID_STEP) : (x_wide - SKID_STEP);

        if (bus.startOfFrame) begin
            case (state_q)
                ST_DRIVE: begin
                    if (pend_now) begin
                        state_d = ST_SKID;
                        cnt_d   = SKID_FRAMES;
                        pend_d  = 1'b0;
                        dir_d   = dir_now;
                    end else if (off_road(key_x)) begin
                        x_d     = clamp_road(key_x);
                        state_d = ST_CRASH;
                        cnt_d   = CRASH_FRAMES;
                        vis_d   = 1'b0;
                    end else begin
                        x_d = key_x[10:0];
                    end
                end
                ST_SKID: begin
                    if (off_road(skid_x)) begin
                        x_d     = clamp_road(skid_x);
                        state_d = ST_CRASH;
                        cnt_d   = CRASH_FRAMES;
                        vis_d   = 1'b0;
                    end else begin
                        x_d   = skid_x[10:0];
                        cnt_d = cnt_dec;
                        if (cnt_dec == 8'd0)
                            state_d = ST_DRIVE;
                    end
                end
                ST_CRASH: begin
                    vis_d = 1'b0;
                    cnt_d = cnt_dec;
                    if (cnt_dec == 8'd0) begin
                        x_d     = INIT_X;
                        state_d = ST_RESPAWN;
                        cnt_d   = RESPAWN_FRAMES;
                        vis_d   = 1'b1;
                    end
                end
                ST_RESPAWN: begin
                    x_d   = clamp_road(key_x);
                    cnt_d = cnt_dec;
                    if (cnt_dec == 8'd0) begin
                        state_d = ST_DRIVE;
                        vis_d   = 1'b1;
                    end else begin
                        vis_d = cnt_dec[2];
                    end
                end
                default: begin
                    state_d = ST_DRIVE;
                    vis_d   = 1'b1;
                    pend_d  = 1'b0;
                end
            endcase
        end else if (state_q == ST_DRIVE && bus.collision) begin
            pend_d = 1'b1;
            dir_d  = bus.skidDir;
        end
    end

    // State registers with synchronous reset to the spawn position
    always_ff @(posedge clk) begin
        if (reset) begin
            x_q     <= INIT_X;
            vis_q   <= 1'b1;
            state_q <= ST_DRIVE;
            cnt_q   <= 8'd0;
            pend_q  <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            x_q     <= x_d;
            vis_q   <= vis_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            dir_q   <= dir_d;
        end
    end

    assign bus.topLeftX   = x_q;
    assign bus.carVisible = vis_q;
    assign bus.carState   = state_q;

`ifdef CAR_CRASH_COUNT_EN
    logic [3:0] crash_cnt_q, crash_cnt_d;

    // Count each fresh entry into CRASH, holding at the maximum value
    always_comb begin
        crash_cnt_d = crash_cnt_q;
        if (state_d == ST_CRASH && state_q != ST_CRASH && crash_cnt_q != 4'd15)
            crash_cnt_d = crash_cnt_q + 4'd1;
    end

    // Crash counter register, cleared by reset
    always_ff @(posedge clk) begin
        if (reset)
            crash_cnt_q <= 4'd0;
        else
            crash_cnt_q <= crash_cnt_d;
    end

    assign bus.crashCount = crash_cnt_q;
`endif

endmodule

// File: tb/tb_car_x_controller.sv
// Testbench for car_x_controller: directed scenarios plus randomized frames,
// checked against a frame-level behavioural model.
module tb_car_x_controller;

    logic clk = 1'b0;
    logic reset;

    car_x_controller_if bus ();

    car_x_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 10 ns pixel clock
    always #5 clk = ~clk;

    localparam int P_DRIVE   = 0;
    localparam int P_SKID    = 1;
    localparam int P_CRASH   = 2;
    localparam int P_RESPAWN = 3;

    int tests    = 0;
    int failures = 0;

    int m_x;
    int m_phase;
    int m_left;
    int m_vis;
    int m_crash_cnt;
    int m_crash_entries = 0;
    bit m_hit;
    bit m_dir;

    function automatic int roadClamp(input int v);
        if (v < 160) return 160;
        if (v > 448) return 448;
        return v;
    endfunction

    // Behavioural model: one call per clock edge with the inputs seen at that edge
    task automatic modelCycle(input bit rst, input bit sof, input bit l, input bit r,
                              input bit c, input bit d);
        int want;
        if (rst) begin
            m_x = 310; m_vis = 1; m_phase = P_DRIVE; m_left = 0;
            m_hit = 0; m_dir = 0; m_crash_cnt = 0;
            return;
        end
        if (!sof) begin
            if (m_phase == P_DRIVE && c) begin
                m_hit = 1; m_dir = d;
            end
            return;
        end
        want = m_x;
        if (l && !r) want = m_x - 2;
        if (r && !l) want = m_x + 2;
        case (m_phase)
            P_DRIVE: begin
                if (m_hit || c) begin
                    if (c) m_dir = d;
                    m_hit = 0; m_phase = P_SKID; m_left = 16;
                end else if (want != roadClamp(want)) begin
                    m_x = roadClamp(want); m_phase = P_CRASH; m_left = 30; m_vis = 0;
                    m_crash_entries++;
                    if (m_crash_cnt < 15) m_crash_cnt++;
                end else begin
                    m_x = want;
                end
            end
            P_SKID: begin
                want = m_x + (m_dir ? 4 : -4);
                if (want != roadClamp(want)) begin
                    m_x = roadClamp(want); m_phase = P_CRASH; m_left = 30; m_vis = 0;
                    m_crash_entries++;
                    if (m_crash_cnt < 15) m_crash_cnt++;
                end else begin
                    m_x = want;
                    m_left--;
                    if (m_left == 0) m_phase = P_DRIVE;
                end
            end
            P_CRASH: begin
                m_left--;
                if (m_left == 0) begin
                    m_x = 310; m_phase = P_RESPAWN; m_left = 60; m_vis = 1;
                end
            end
            default: begin
                m_x = roadClamp(want);
                m_left--;
                if (m_left == 0) begin
                    m_phase = P_DRIVE; m_vis = 1;
                end else begin
                    m_vis = (m_left / 4) % 2;
                end
            end
        endcase
    endtask

    // Drive one cycle of inputs from a falling edge, update the model at the rising edge
    task automatic applyStimulus(input bit rst, input bit sof, input bit l, input bit r,
                                 input bit c, input bit d);
        reset            = rst;
        bus.startOfFrame = sof;
        bus.leftKey      = l;
        bus.rightKey     = r;
        bus.collision    = c;
        bus.skidDir      = d;
        @(posedge clk);
        modelCycle(rst, sof, l, r, c, d);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_x"},     bus.topLeftX,   m_x);
        checkOutput({tag, "_vis"},   bus.carVisible, m_vis);
        checkOutput({tag, "_state"}, bus.carState,   m_phase);
`ifdef CAR_CRASH_COUNT_EN
        checkOutput({tag, "_crashes"}, bus.crashCount, m_crash_cnt);
`endif
    endtask

    // Optional collision cycle, then idle cycles, then the frame tick itself
    task automatic runFrame(input bit l, input bit r, input bit c_between, input bit c_tick,
                            input bit d, input int gap);
        if (c_between)
            applyStimulus(0, 0, l, r, 1, d);
        for (int g = 0; g < gap; g++)
            applyStimulus(0, 0, l, r, 0, d);
        applyStimulus(0, 1, l, r, c_tick, d);
    endtask

    // Directed scenarios followed by a randomized run
    initial begin
        bit kl, kr;
        reset            = 1'b1;
        bus.startOfFrame = 1'b0;
        bus.leftKey      = 1'b0;
        bus.rightKey     = 1'b0;
        bus.collision    = 1'b0;
        bus.skidDir      = 1'b0;
        @(negedge clk);
        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("reset_x", bus.topLeftX, 310);
        checkOutput("reset_vis", bus.carVisible, 1);
        checkOutput("reset_state", bus.carState, 0);
        checkAll("reset");

        for (int i = 0; i < 10; i++)
            runFrame(0, 1, 0, 0, 0, $urandom_range(0, 2));
        checkOutput("right10_x", bus.topLeftX, 330);
        checkOutput("right10_state", bus.carState, 0);
        checkOutput("right10_vis", bus.carVisible, 1);

        for (int i = 0; i < 59; i++)
            runFrame(0, 1, 0, 0, 0, $urandom_range(0, 1));
        checkOutput("edge69_x", bus.topLeftX, 448);
        checkOutput("edge69_state", bus.carState, 0);
        runFrame(0, 1, 0, 0, 0, 0);
        checkOutput("crash70_x", bus.topLeftX, 448);
        checkOutput("crash70_state", bus.carState, 2);
        checkOutput("crash70_vis", bus.carVisible, 0);

        for (int i = 1; i < 30; i++) begin
            runFrame($urandom_range(0, 1), $urandom_range(0, 1), 0, 0, 0, $urandom_range(0, 2));
            checkAll("crash_hold");
        end
        checkOutput("crash29_state", bus.carState, 2);
        runFrame(0, 0, 0, 0, 0, 1);
        checkOutput("respawn_x", bus.topLeftX, 310);
        checkOutput("respawn_state", bus.carState, 3);
        checkOutput("respawn_vis", bus.carVisible, 1);

        for (int i = 1; i < 60; i++) begin
            runFrame($urandom_range(0, 1), $urandom_range(0, 1), i % 3 == 0, i % 7 == 0,
                     $urandom_range(0, 1), $urandom_range(0, 2));
            checkAll("respawn_blink");
            checkOutput("respawn_keep_state", bus.carState, 3);
        end
        runFrame(0, 0, 0, 0, 0, 1);
        checkOutput("respawn_done_state", bus.carState, 0);
        checkOutput("respawn_done_vis", bus.carVisible, 1);
        checkAll("respawn_done");

        applyStimulus(1, 0, 0, 0, 0, 0);
        checkAll("reset2");
        runFrame($urandom_range(0, 1), $urandom_range(0, 1), 1, 0, 0, $urandom_range(0, 2));
        checkOutput("skid_enter_state", bus.carState, 1);
        checkOutput("skid_enter_x", bus.topLeftX, 310);
        for (int i = 0; i < 15; i++) begin
            runFrame($urandom_range(0, 1), $urandom_range(0, 1), 0, 0, 0, $urandom_range(0, 2));
            checkAll("skid_run");
        end
        checkOutput("skid15_state", bus.carState, 1);
        runFrame($urandom_range(0, 1), $urandom_range(0, 1), 0, 0, 0, 0);
        checkOutput("skid_end_x", bus.topLeftX, 246);
        checkOutput("skid_end_state", bus.carState, 0);
        checkOutput("skid_end_vis", bus.carVisible, 1);

        runFrame(1, 1, 0, 0, 0, 1);
        checkOutput("both_keys_x", bus.topLeftX, 246);
        checkOutput("both_keys_state", bus.carState, 0);
        runFrame(0, 0, 0, 1, 1, 0);
        checkOutput("coll_at_tick_state", bus.carState, 1);
        checkOutput("coll_at_tick_x", bus.topLeftX, 246);
        runFrame(1, 0, 0, 0, 0, 0);
        runFrame(1, 0, 0, 0, 0, 0);
        checkOutput("skid_right_x", bus.topLeftX, 254);
        checkAll("skid_right");

        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("reset_skid_x", bus.topLeftX, 310);
        checkOutput("reset_skid_state", bus.carState, 0);
        checkOutput("reset_skid_vis", bus.carVisible, 1);

        for (int i = 0; i < 76; i++)
            runFrame(1, 0, 0, 0, 0, 0);
        checkOutput("left_crash_x", bus.topLeftX, 160);
        checkOutput("left_crash_state", bus.carState, 2);
        runFrame(0, 0, 0, 0, 0, 0);
        runFrame(0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("reset_crash_x", bus.topLeftX, 310);
        checkOutput("reset_crash_state", bus.carState, 0);
        checkOutput("reset_crash_vis", bus.carVisible, 1);
        checkAll("reset_crash");

        for (int i = 0; i < 300; i++) begin
            kl = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            kr = $urandom_range(0, 1);
            if ($urandom_range(0, 99) == 0)
                applyStimulus(1, 0, 0, 0, 0, 0);
            runFrame(kl ^ kr ? kl : $urandom_range(0, 1), kr,
                     $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                     $urandom_range(0, 1), $urandom_range(0, 3));
            checkAll("random");
        end

`ifdef CAR_CRASH_COUNT_EN
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("crash_count_reset", bus.crashCount, 0);
        m_crash_entries = 0;
        for (int i = 0; i < 4000 && m_crash_entries < 16; i++) begin
            runFrame(0, 1, 0, 0, 0, 0);
            checkAll("crash_loop");
        end
        checkOutput("crash_loop_entries", m_crash_entries, 16);
        checkOutput("crash_count_sat", bus.crashCount, 15);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    // Global time bound so the run can never hang
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] time limit reached");
    end

endmodule

// File: doc/car_x_controller.md
Name: car_x_controller

Overview:
- Sequences the player car's horizontal top-left X position, frame by frame. Replaces the fixed X constant of 310 that feeds the car sprite/object block.
- Moves the car on the keyboard left/right keys, runs the skid, crash and respawn sequences, and drives sprite visibility.
- Sits between the keyboard/collision logic and the car square/bitmap object, clocked on the pixel clock.

Parameters:
- INIT_X, 310, spawn and reset X (signed 11-bit)
- ROAD_LEFT, 160, minimum legal top-left X
- ROAD_RIGHT, 448, maximum legal top-left X
- STEP, 2, pixels per frame under key control
- SKID_STEP, 4, pixels per frame while skidding
- SKID_FRAMES, 16, skid duration in frames (1..255)
- CRASH_FRAMES, 30, frames the car is hidden after a crash (1..255)
- RESPAWN_FRAMES, 60, blink/invulnerable duration in frames (1..255)

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  single-cycle pulse, once per frame
- leftKey  in  1  level, left key held
- rightKey  in  1  level, right key held
- collision  in  1  single-cycle pulse from the collision detector
- skidDir  in  1  skid direction, sampled with collision (1 = right, 0 = left)
- topLeftX  out  signed 11  car X position
- carVisible  out  1  sprite enable
- carState  out  2  0 = DRIVE, 1 = SKID, 2 = CRASH, 3 = RESPAWN

Behaviour:
- Reset (sync, any state, mid-sequence included): on the next edge topLeftX=INIT_X, carVisible=1, carState=DRIVE, frame counter=0, collision latch=0, skid direction=0.
- All outputs are registered. State and X change only on an edge where startOfFrame=1. The new value is visible the cycle after that pulse.
- Collision latch:
  - In DRIVE, collision=1 on any cycle sets pending and captures skidDir.
  - collision on the same cycle as startOfFrame is consumed by that frame tick.
  - pending is cleared on entry to any non-DRIVE state. Collisions are ignored outside DRIVE.
- Arithmetic: next X is computed 12-bit signed (no wrap), then compared with the bounds.
  - X == ROAD_LEFT and X == ROAD_RIGHT are legal.
  - Beyond a bound: clamp X to that bound.
- DRIVE, per frame tick:
  - If pending: enter SKID, counter=SKID_FRAMES, X unchanged this tick.
  - Else leftKey only: X-=STEP. rightKey only: X+=STEP. Both keys or neither: hold.
  - If the step exceeds a bound: clamp, enter CRASH, counter=CRASH_FRAMES, carVisible=0.
- SKID, per tick:
  - Keys ignored. X moves SKID_STEP in the latched direction; counter decrements.
  - Bound exceeded: clamp and enter CRASH. This takes precedence over counter expiry.
  - Counter reaching 0: enter DRIVE.
  - The skid lasts exactly SKID_FRAMES ticks.
- CRASH, per tick:
  - X held, carVisible=0, counter decrements.
  - On reaching 0: X=INIT_X, enter RESPAWN, counter=RESPAWN_FRAMES, carVisible=1.
- RESPAWN, per tick:
  - Keys move X as in DRIVE, but a bound clamps without crashing.
  - carVisible toggles every 4 ticks, driven by counter[2].
  - Counter decrements; at 0: enter DRIVE, carVisible=1.
- No other state transitions exist. The unused encoding recovers to DRIVE on the next tick.

Optional Feature:
- Macro CAR_CRASH_COUNT_EN.
- Defined: adds output crashCount (out, 4 bits), reset 0. Increments by 1 on each entry to CRASH and saturates at 15. Updates in the same cycle as carState.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then rightKey held for 10 frame pulses -> topLeftX=330, carState=0, carVisible=1.
- rightKey held from 310 -> 448 after 69 frames; 70th frame -> topLeftX=448, carState=2, carVisible=0.
- Collision pulse with skidDir=0 at X=310, between frames -> carState=1 at next frame; 16 frames later X=246, carState=0; keys ignored throughout.
- After the crash in scenario 2 -> after 30 frames X=310, carState=3; carVisible toggles every 4 frames; after 60 frames carState=0, carVisible=1; collisions in RESPAWN have no effect.
- Collision coincident with startOfFrame -> SKID on that tick. leftKey+rightKey together -> X unchanged.
- Reset asserted mid-SKID and mid-CRASH -> next edge X=310, carState=0, carVisible=1. With CAR_CRASH_COUNT_EN, 16 forced crashes -> crashCount=15.
